// File: rtl/uart_tx_fifo_if.sv
// Byte-write / status bundle between the controller's send logic and the UART transmitter.
interface uart_tx_fifo_if;
    logic [7:0] txdata;
    logic       dataValid;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;

    modport master (output txdata, dataValid, input tx, busy, full, overflow);
    modport slave  (input txdata, dataValid, output tx, busy, full, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO: 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
// The serial line and status outputs are all registered.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input logic         clk,
    input logic         rst,
    uart_tx_fifo_if.slave bus
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [CntW-1:0] BaudLast  = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic [CntW-1:0] baud_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            tx_q, tx_d;
    logic            busy_q, full_q, overflow_q;
    logic            wr_en, pop, baud_done;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
`endif

    // Full is the registered pre-edge value, so a write racing a pop while full is dropped.
    assign wr_en     = bus.dataValid & ~full_q;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign baud_done = (baud_q == BaudLast);

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (pop) state_d = StStart;
            StStart:  if (baud_done) state_d = StData;
`ifdef UART_TX_PARITY_EN
            StData:   if (baud_done && bit_idx_q == 3'd7) state_d = StParity;
            StParity: if (baud_done) state_d = StStop;
`else
            StData:   if (baud_done && bit_idx_q == 3'd7) state_d = StStop;
`endif
            StStop:   if (baud_done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Line level is derived from the current state and registered, so tx trails state by a cycle.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.txdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            count_q    <= count_d;
            full_q     <= (count_d == FullCount);
            overflow_q <= bus.dataValid & full_q;
            busy_q     <= (state_q != StIdle) || (count_q != '0);
            tx_q       <= tx_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PtrW'(1);
                shift_q   <= mem_q[rd_ptr_q];
                baud_q    <= '0;
                bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                parity_q  <= ^mem_q[rd_ptr_q];
`endif
            end else if (state_q != StIdle) begin
                if (baud_done) begin
                    baud_q <= '0;
                    if (state_q == StData) begin
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_q <= baud_q + CntW'(1);
                end
            end
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4); honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         start;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    frame_t rx_q[$];

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.txdata    = b;
        bus.dataValid = 1'b1;
        tick(1);
        bus.dataValid = 1'b0;
        bus.txdata    = 'x;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (rx_q.size() >= n) break;
            tick(1);
        end
        tick(3 * FRAME);
        check_eq(tag, 32'(rx_q.size()), 32'(n));
    endtask

    // Line decoder: samples mid-bit after each falling edge seen on tx.
    initial begin : rx_mon
        frame_t f;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b0 && bus.tx === 1'b0) begin
                f.start = cyc;
                f.data  = '0;
                f.par   = 1'b0;
                tick(2);
                for (int i = 0; i < 8; i++) begin
                    tick(CPB);
                    f.data[i] = bus.tx;
                end
`ifdef UART_TX_PARITY_EN
                tick(CPB);
                f.par = bus.tx;
`endif
                tick(CPB);
                f.stop = bus.tx;
                rx_q.push_back(f);
            end
        end
    end

    initial begin
        logic [NB-1:0] exp_frame;
        logic [7:0]    exp_bytes [5];
        int            lows;

        rst           = 1'b1;
        bus.dataValid = 1'b0;
        bus.txdata    = 'x;

        // Reset state
        tick(3);
        check_eq("rst_tx", 32'(bus.tx), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_full", 32'(bus.full), 32'd0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_eq("idle_tx", 32'(bus.tx), 32'd1);
        end

        // Single byte 0xA5, line pattern listed LSB-first from bit 0
`ifdef UART_TX_PARITY_EN
        exp_frame = 11'b10101001010;
`else
        exp_frame = 10'b1101001010;
`endif
        send(8'hA5);
        check_eq("lat_edge_n", 32'(bus.tx), 32'd1);
        tick(1);
        check_eq("lat_edge_n1", 32'(bus.tx), 32'd1);
        check_eq("busy_rise", 32'(bus.busy), 32'd1);
        for (int c = 0; c < FRAME; c++) begin
            tick(1);
            check_eq("a5_line", 32'(bus.tx), 32'(exp_frame[c / CPB]));
            check_eq("a5_busy", 32'(bus.busy), 32'd1);
        end
        tick(1);
        check_eq("a5_busy_fall", 32'(bus.busy), 32'd0);
        check_eq("a5_tx_idle", 32'(bus.tx), 32'd1);
        tick(5);
        rx_q.delete();

        // Burst 01..06: 01 pops immediately, 02..05 fill, 06 is dropped
        for (int i = 0; i < 6; i++) begin
            send(8'(i + 1));
            if (i == 3) check_eq("burst_full_3", 32'(bus.full), 32'd0);
            if (i == 4) begin
                check_eq("burst_full_4", 32'(bus.full), 32'd1);
                check_eq("burst_ovf_4", 32'(bus.overflow), 32'd0);
            end
            if (i == 5) check_eq("burst_ovf_5", 32'(bus.overflow), 32'd1);
        end
        tick(1);
        check_eq("burst_ovf_end", 32'(bus.overflow), 32'd0);
        wait_frames("burst_frames", 5, 400);
        for (int k = 0; k < rx_q.size() && k < 5; k++) begin
            check_eq("burst_data", 32'(rx_q[k].data), 32'(k + 1));
            check_eq("burst_stop", 32'(rx_q[k].stop), 32'd1);
            if (k > 0)
                check_eq("burst_gap", 32'(rx_q[k].start - rx_q[k-1].start), 32'(FRAME + 1));
        end
        check_eq("burst_busy_done", 32'(bus.busy), 32'd0);
        rx_q.delete();

        // Overflow with 0xFF while full during a frame
        exp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        send(8'h10);
        tick(4);
        for (int i = 1; i < 5; i++) send(exp_bytes[i]);
        check_eq("ovf_full", 32'(bus.full), 32'd1);
        send(8'hFF);
        check_eq("ovf_pulse", 32'(bus.overflow), 32'd1);
        tick(1);
        check_eq("ovf_pulse_one", 32'(bus.overflow), 32'd0);
        wait_frames("ovf_frames", 5, 400);
        for (int k = 0; k < rx_q.size() && k < 5; k++)
            check_eq("ovf_data", 32'(rx_q[k].data), 32'(exp_bytes[k]));
        rx_q.delete();

        // Reset in the middle of 0x3C's data bits with two bytes queued
        send(8'h3C);
        send(8'hAA);
        send(8'h55);
        for (int k = 0; k < 50; k++) begin
            if (bus.tx === 1'b0) break;
            tick(1);
        end
        check_eq("rst_frame_start", 32'(bus.tx), 32'd0);
        tick(10);
        check_eq("rst_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick(1);
        check_eq("midrst_tx", 32'(bus.tx), 32'd1);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_full", 32'(bus.full), 32'd0);
        rst  = 1'b0;
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) lows++;
        end
        check_eq("midrst_quiet", 32'(lows), 32'd0);
        rx_q.delete();

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 has three ones, 0x03 has two
        send(8'h07);
        send(8'h03);
        wait_frames("par_frames", 2, 300);
        if (rx_q.size() == 2) begin
            check_eq("par07_data", 32'(rx_q[0].data), 32'h07);
            check_eq("par07_bit", 32'(rx_q[0].par), 32'd1);
            check_eq("par07_stop", 32'(rx_q[0].stop), 32'd1);
            check_eq("par03_data", 32'(rx_q[1].data), 32'h03);
            check_eq("par03_bit", 32'(rx_q[1].par), 32'd0);
            check_eq("par_frame_len", 32'(rx_q[1].start - rx_q[0].start), 32'(FRAME + 1));
        end
        rx_q.delete();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
